// File: rtl/ha_sched_pkg.sv
// Shared definitions for the bit-serial half-adder scheduler.
package ha_sched_pkg;

    // Default operand/result width.
    localparam int unsigned DefaultWidth = 8;

    // Scheduler state encoding.
    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StPhA  = 2'd1;
    localparam state_t StPhB  = 2'd2;
    localparam state_t StDone = 2'd3;

endpackage

// File: rtl/ha_cell.sv
// Single half-adder cell: s = x ^ y, c = x & y.
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/ha_serial_sched.sv
// Bit-serial adder: one half-adder time-multiplexed over two phases per bit, LSB first.
// PH_A adds a[i]+b[i]; PH_B folds the running carry into that partial sum.
module ha_serial_sched
    import ha_sched_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The bit index is held one-hot; this value selects bit 0.
    localparam logic [WIDTH-1:0] SelFirst = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             s1_q, s1_d;
    logic             c1_q, c1_d;
    logic             cout_q, cout_d;

    logic a_bit, b_bit;
    logic ha_x, ha_y, ha_s, ha_c;

    // Operand bits at the current index.
    assign a_bit = |(a_q & sel_q);
    assign b_bit = |(b_q & sel_q);

    // Half-adder input mux: operand bits in PH_A, partial sum and carry in PH_B.
    always_comb begin
        ha_x = a_bit;
        ha_y = b_bit;
        if (state_q == StPhB) begin
            ha_x = s1_q;
            ha_y = carry_q;
        end
    end

    ha_cell u_ha_cell (
        .x (ha_x),
        .y (ha_y),
        .s (ha_s),
        .c (ha_c)
    );

    // Next-state and datapath update for each scheduler phase.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        cout_d  = cout_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sel_d   = SelFirst;
                    carry_d = 1'b0;
                    state_d = StPhA;
                end
            end
            StPhA: begin
                s1_d    = ha_s;
                c1_d    = ha_c;
                state_d = StPhB;
            end
            StPhB: begin
                sum_d   = (sum_q & ~sel_q) | (sel_q & {WIDTH{ha_s}});
                carry_d = c1_q | ha_c;
                if (sel_q[WIDTH-1]) begin
                    cout_d  = c1_q | ha_c;
                    state_d = StDone;
                end else begin
                    sel_d   = sel_q << 1;
                    state_d = StPhA;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= SelFirst;
            sum_q   <= '0;
            carry_q <= 1'b0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            cout_q  <= cout_d;
        end
    end

    // Status decodes from registered state only.
    assign ready = (state_q == StIdle);
    assign busy  = (state_q == StPhA) || (state_q == StPhB);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_ha_serial_sched.sv
// Bench for ha_serial_sched: directed table, multi-cycle corner cases, random scoreboard.
module tb_ha_serial_sched;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    ha_serial_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           mode;  // 0: hold operands, 1: zero after accept, 2: randomise
    } vec_t;

    vec_t vecs[8];
    logic [W:0] sb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Starts one operation from an IDLE cycle and waits (bounded) for done.
    // Returns result, done cycle relative to the accepting cycle, and busy-cycle count.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int mode,
                         input bit noise, output logic [W-1:0] rs, output logic rc,
                         output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        rs   = '0;
        rc   = 1'b0;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (busy) bcnt++;
            if (done) begin
                rs  = sum;
                rc  = cout;
                lat = cyc;
                break;
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (mode == 1) begin
                a = '0;
                b = '0;
            end else if (mode == 2) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
        end
        // DONE cycle: a start here must also be ignored.
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        int           bcnt;
        int           ndone;
        int           last_done;
        logic [W:0]   exp;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 0};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1, 0};
        vecs[3] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 1};
        vecs[4] = '{8'h03, 8'h04, 8'h07, 1'b0, 0};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 2};
        vecs[6] = '{8'h12, 8'h34, 8'h46, 1'b0, 2};
        vecs[7] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors
        foreach (vecs[k]) begin
            do_op(vecs[k].va, vecs[k].vb, vecs[k].mode, 1'b0, rs, rc, lat, bcnt);
            check($sformatf("vec%0d_sum", k), 32'(rs), 32'(vecs[k].exp_sum));
            check($sformatf("vec%0d_cout", k), 32'(rc), 32'(vecs[k].exp_cout));
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'd17);
            check($sformatf("vec%0d_busy_cycles", k), 32'(bcnt), 32'd16);
            check($sformatf("vec%0d_idle_ready", k), 32'(ready), 32'd1);
            check($sformatf("vec%0d_hold_sum", k), 32'({cout, sum}),
                  32'({vecs[k].exp_cout, vecs[k].exp_sum}));
        end

        // Start held high: one result per 18 cycles, operands only latched in IDLE
        ndone     = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 72; cyc++) begin
            if (cyc % 18 == 0) begin
                a = 8'h03;
                b = 8'h04;
            end else begin
                a = 8'h10;
                b = 8'h20;
            end
            start = 1'b1;
            tick();
            if (done) begin
                ndone++;
                check("held_sum", 32'({cout, sum}), 32'h007);
                check("held_done_phase", 32'((cyc + 1) % 18), 32'd17);
                if (last_done >= 0) check("held_period", 32'(cyc + 1 - last_done), 32'd18);
                last_done = cyc + 1;
            end
        end
        check("held_done_count", 32'(ndone), 32'd4);
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        check("held_end_ready", 32'(ready), 32'd1);

        // Reset mid-operation (cycle 9): abort, clear results, no done pulse
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 9; cyc++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        // Reset and start on the same edge: reset wins
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_ready", 32'(ready), 32'd1);
        check("rst_prio_busy", 32'(busy), 32'd0);

        // Random operations against the arithmetic model
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            int           gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            av  = W'($urandom);
            bv  = W'($urandom);
            sb_q.push_back({1'b0, av} + {1'b0, bv});
            do_op(av, bv, int'($urandom_range(0, 2)), 1'b1, rs, rc, lat, bcnt);
            exp = sb_q.pop_front();
            check("rand_result", 32'({rc, rs}), 32'(exp));
            check("rand_latency", 32'(lat), 32'd17);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
